alu_op_sequencer: RTL and testbench

Shared-ALU controller for the 8-bit bitwise/shift datapath. Arbitrates operation requests from two requesters round-robin, latches one request at a time, executes logic ops in one cycle and shift/rotate ops iteratively (one bit position per cycle), and returns the result on a valid/ready result port tagged with the requester id. It sits between the requester front-ends and the gate-level bitwise units.

---
 rtl/alu_op_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Shared 8-bit bitwise/shift ALU controller: round-robin arbitration between two
// requesters, single-cycle logic ops, one-bit-per-cycle shifts, valid/ready result port.
module alu_op_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              res_zero
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic              last_id;
  logic [SH_W-1:0]   count;
  logic [2:0]        op_q;

  logic              grant_vld;
  logic              grant_id;
  logic [2:0]        acc_op;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic [SH_W-1:0]   acc_n;

  function automatic logic is_shift(input logic [2:0] op);
    return op[2] && (op != 3'b111);
  endfunction

  function automatic logic [DATA_W-1:0] logic_result(input logic [2:0] op,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
    case (op)
      3'b000:  return a | b;
      3'b001:  return a & b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      default: return a;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] shift_step(input logic [2:0] op,
                                                    input logic [DATA_W-1:0] v);
    case (op)
      3'b100:  return {v[DATA_W-2:0], 1'b0};
      3'b101:  return {1'b0, v[DATA_W-1:1]};
      default: return {v[DATA_W-2:0], v[DATA_W-1]};
    endcase
  endfunction

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant_vld  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? ~last_id : req1_valid;
    acc_op     = grant_id ? req1_op : req0_op;
    acc_a      = grant_id ? req1_a  : req0_a;
    acc_b      = grant_id ? req1_b  : req0_b;
    acc_n      = acc_b[SH_W-1:0];
    req0_ready = (state == IDLE) && grant_vld && !grant_id && !rst;
    req1_ready = (state == IDLE) && grant_vld &&  grant_id && !rst;
  end

  assign res_zero = (res_data == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      last_id   <= 1'b1;
      count     <= '0;
      op_q      <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q    <= acc_op;
            res_id  <= grant_id;
            last_id <= grant_id;
            if (is_shift(acc_op) && (acc_n != '0)) begin
              res_data <= acc_a;
              count    <= acc_n;
              state    <= SHIFT;
            end else begin
              res_data  <= is_shift(acc_op) ? acc_a : logic_result(acc_op, acc_a, acc_b);
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        // res_data doubles as the shift register while iterating.
        SHIFT: begin
          res_data <= shift_step(op_q, res_data);
          count    <= count - SH_W'(1);
          if (count == SH_W'(1)) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a cycle-level behavioural scoreboard
// plus literal expectations for each scenario.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_id, res_zero;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  alu_op_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_zero(res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Expected result from the opcode table, in plain arithmetic.
  function automatic logic [7:0] model_res(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    int n;
    logic [15:0] w;
    n = b % 8;
    w = {a, a} << n;
    case (op)
      3'd0: return a | b;
      3'd1: return a & b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a << n;
      3'd5: return a >> n;
      3'd6: return w[15:8];
      default: return a;
    endcase
  endfunction

  // Scoreboard: busy flag, remaining latency, held result.
  bit       m_busy = 0, m_vld = 0, m_last = 1, m_id = 0, m_pid = 0;
  logic [7:0] m_data = 0, m_pend = 0;
  int       m_wait = 0;

  function automatic bit exp_ready(input int k);
    bit mine, other;
    mine  = (k == 0) ? req0_valid : req1_valid;
    other = (k == 0) ? req1_valid : req0_valid;
    return !rst && !m_busy && mine && (!other || (m_last != k[0]));
  endfunction

  always @(posedge clk) begin
    bit g0, g1, id;
    logic [2:0] op;
    logic [7:0] a, b;
    g0 = exp_ready(0);
    g1 = exp_ready(1);
    if (rst) begin
      m_busy = 0; m_vld = 0; m_data = 0; m_id = 0; m_last = 1; m_wait = 0;
    end else if (!m_busy) begin
      if (g0 || g1) begin
        id = g1;
        op = id ? req1_op : req0_op;
        a  = id ? req1_a  : req0_a;
        b  = id ? req1_b  : req0_b;
        m_last = id;
        m_busy = 1;
        m_pend = model_res(op, a, b);
        m_pid  = id;
        m_wait = (op >= 3'd4 && op <= 3'd6) ? (b % 8) : 0;
        if (m_wait == 0) begin
          m_vld = 1; m_data = m_pend; m_id = id;
        end
      end
    end else if (!m_vld) begin
      m_wait--;
      if (m_wait == 0) begin
        m_vld = 1; m_data = m_pend; m_id = m_pid;
      end
    end else if (res_ready) begin
      m_vld = 0;
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_res_valid", res_valid, m_vld);
      chk("sb_req0_ready", req0_ready, exp_ready(0));
      chk("sb_req1_ready", req1_ready, exp_ready(1));
      if (!m_busy || m_vld) begin
        chk("sb_res_data", res_data, m_data);
        chk("sb_res_id", res_id, m_id);
        chk("sb_res_zero", res_zero, m_data == 8'h00);
      end
    end
  end

  task automatic drive(input int k, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    if (k == 0) begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic run_op(input int k, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int lat);
    bit got;
    int c;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drive(k, op, a, b);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (k == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk("run_op_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    c = 1;
    @(negedge clk);
    while (!res_valid && c < 20) begin
      c++;
      @(negedge clk);
    end
    chk("run_op_latency", c, lat);
    chk("run_op_data", res_data, exp);
    chk("run_op_id", res_id, k[0]);
    chk("run_op_zero", res_zero, exp == 8'h00);
    @(negedge clk);
    chk("run_op_valid_one_cycle", res_valid, 0);
  endtask

  int gid[$];
  int gcyc[$];

  initial begin
    rst = 1; res_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1; req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_data", res_data, 8'h00);
    chk("reset_res_zero", res_zero, 1);
    @(posedge clk); #1 rst = 0; req0_valid = 0; req1_valid = 0;

    run_op(0, 3'd0, 8'hA5, 8'h0F, 8'hAF, 1);
    run_op(0, 3'd1, 8'hF0, 8'h0F, 8'h00, 1);

    // Round robin from a fresh reset: requester 0 wins the first tie.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    drive(0, 3'd2, 8'h11, 8'h22);
    drive(1, 3'd2, 8'h33, 8'h0F);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
      if (req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
    end
    chk("rr_grant_count", gid.size() >= 4, 1);
    if (gid.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_grant_order", gid[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_grant_spacing", gcyc[i] - gcyc[i-1], 2);
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    repeat (12) @(posedge clk);

    run_op(1, 3'd2, 8'h0F, 8'hFF, 8'hF0, 1);

    // Shift while the other requester waits.
    @(posedge clk); #1;
    drive(0, 3'd4, 8'h81, 8'h03);
    drive(1, 3'd0, 8'h0C, 8'h30);
    @(negedge clk);
    chk("shl_req0_ready", req0_ready, 1);
    chk("shl_req1_ready", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("shl_res_valid", res_valid, k == 4);
      chk("shl_req1_blocked", req1_ready, 0);
    end
    chk("shl_res_data", res_data, 8'h08);
    chk("shl_res_id", res_id, 0);
    @(negedge clk);
    chk("shl_req1_after_handoff", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    chk("shl_next_data", res_data, 8'h3C);
    chk("shl_next_id", res_id, 1);

    run_op(0, 3'd6, 8'h81, 8'h09, 8'h03, 2);
    run_op(1, 3'd5, 8'h80, 8'h00, 8'h80, 1);
    run_op(0, 3'd3, 8'h00, 8'h00, 8'hFF, 1);
    run_op(1, 3'd7, 8'h5A, 8'hFF, 8'h5A, 1);

    // Backpressure: result held five cycles.
    @(posedge clk); #1 res_ready = 0;
    drive(0, 3'd1, 8'h3C, 8'hF0);
    drive(1, 3'd0, 8'h01, 8'h02);
    @(negedge clk);
    chk("bp_req0_ready", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 8'h30);
      chk("bp_res_id", res_id, 0);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1;
    @(negedge clk);
    chk("bp_handoff_valid", res_valid, 1);
    @(negedge clk);
    chk("bp_next_accept", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    chk("bp_next_data", res_data, 8'h03);

    // Reset in the second SHIFT cycle of SHL by 5.
    @(posedge clk); #1;
    drive(0, 3'd4, 8'hFF, 8'h05);
    @(negedge clk);
    chk("rst_shift_accept", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    drive(0, 3'd0, 8'h01, 8'h10);
    drive(1, 3'd2, 8'hAA, 8'h55);
    @(negedge clk);
    chk("rst_shift_res_valid", res_valid, 0);
    chk("rst_shift_res_data", res_data, 8'h00);
    chk("rst_shift_req0_first", req0_ready, 1);
    chk("rst_shift_req1_wait", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("rst_shift_next_data", res_data, 8'h11);
    repeat (4) @(posedge clk);
    #1 req1_valid = 0;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
